gauss_conv_window: RTL and testbench
====================================

Name: gauss_conv_window

Overview:
- Consumes the normalized Gaussian kernel from the kernel-generation stage (8-bit Q0.8 weights, row-major [y][x]) and convolves it with one kernel_size x kernel_size pixel window at a time.
- Pixels stream in raster order over a valid/ready handshake. Output is one rounded, saturated 8-bit blurred pixel per window.
- Sits between the line-buffer/window-fetch stage and the FAST corner front end.

Parameters:
- MAX_KERNEL, 3: maximum kernel edge length. Kernel array is MAX_KERNEL x MAX_KERNEL.
- PIX_W, 8: pixel width in bits. Weights are fixed at 8 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- kernel_in  in  [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]  normalized weights, Q0.8.
- kernel_size  in  $clog2(MAX_KERNEL+1)  active edge length, legal range 1..MAX_KERNEL.
- kernel_load  in  1  one-cycle pulse; latches kernel_in and kernel_size.
- pix_in  in  PIX_W  window pixel, raster order.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block accepts a pixel this cycle.
- out_pix  out  PIX_W  filtered pixel.
- out_valid  out  1  out_pix is valid; held until accepted.
- out_ready  in  1  downstream accepts out_pix.
- busy  out  1  a window is partially or fully accumulated.
- err  out  1  sticky illegal kernel_size on load.

Behaviour:
- Reset, asynchronous: state=UNARMED; all outputs 0; accumulator, counters, kernel and size registers cleared. Reset mid-window discards the partial sum, and no output is produced for that window.
- States: UNARMED, ACCUM, ROUND, OUT.
- Load acceptance:
  - kernel_load is accepted only in UNARMED, or in ACCUM with zero pixels consumed. Otherwise it is ignored and has no side effects.
  - On accept with kernel_size 1..MAX_KERNEL: latch kernel and size, err<=0, go to ACCUM.
  - On accept with kernel_size 0 or >MAX_KERNEL: err<=1, go to UNARMED.
- ACCUM:
  - pix_ready=1.
  - A handshake (pix_valid & pix_ready) adds pix_in*w[cy][cx] to acc, then advances cx.
  - cx wraps at size-1 and increments cy.
  - When the last pixel (cx=cy=size-1) is accepted, go to ROUND. Counters return to 0.
  - busy=1 once the first pixel has been accepted.
- Accumulator width: ACC_W = PIX_W+8+$clog2(MAX_KERNEL*MAX_KERNEL). It never overflows.
- ROUND, one cycle:
  - res = (acc + ROUND_BIAS) >> 8.
  - If res > 2^PIX_W-1, out_pix <= all-ones; otherwise out_pix <= res[PIX_W-1:0].
  - Go to OUT.
- OUT:
  - out_valid=1 and out_pix stable until out_ready. pix_ready=0 (backpressure).
  - On out_ready: out_valid<=0, acc<=0, busy<=0, go to ACCUM. The kernel stays armed.
- Latency: last pixel accepted at cycle N → out_valid high at N+2. If out_ready is tied high, throughput is size^2+2 cycles per window.
- kernel_load and pix_valid in the same ACCUM cycle with zero pixels consumed: the load takes effect and the pixel is not accepted (pix_ready=0 that cycle).
- Weights are used as-is. The block does not check that the sum equals 256.

Optional Feature:
- GAUSS_ROUND_EN:
  - Defined: ROUND_BIAS = 128, round-half-up.
  - Undefined: ROUND_BIAS = 0, truncation.
  - Saturation, latency and the handshake are identical in both builds.

Decomposition:
- Package gauss_pkg:
  - KERNEL_FRAC_BITS=8.
  - conv_state_t enum {UNARMED, ACCUM, ROUND, OUT}.
  - ACC_W function of MAX_KERNEL and PIX_W.
- Sub-module gauss_mac: registered multiply-accumulate with clear and enable (pixel × weight → acc).
- The cx/cy counters reuse the existing FlexCounter.

Test Plan:
- Load size=3, only center weight=255. Pixels 10,20,...,40,200,60,...,90 → out_pix=199 in both builds (51000 → 199). out_valid rises 2 cycles after the 9th handshake.
- Load size=3, all weights=28. Nine pixels of 255 → acc=64260 → out_pix=251 with GAUSS_ROUND_EN, and 251 without.
- All weights=255, size=3, pixels=255 → acc=585225 → out_pix saturates to 255.
- kernel_load with kernel_size=0 → err=1, pix_ready=0. Then a load with size=2 → err=0. A 4-pixel window of 100 with weights 64 each → out_pix=100.
- Hold out_ready=0 for 5 cycles in OUT → out_valid and out_pix stable, pix_ready=0. Assert out_ready → a new window is accepted next cycle.
- Assert rst after 4 of 9 pixels → all outputs 0, state UNARMED. pix_ready stays 0 until a new kernel_load.

Source files
------------

// File: rtl/gauss_pkg.sv
// ============================================================================
// Module   : gauss_pkg
// Purpose  : Shared types and constants for the Gaussian window convolver.
//            Kernel weights are Q0.8 (KERNEL_FRAC_BITS fractional bits).
// Config   : GAUSS_ROUND_EN -- defined: round-half-up (bias 128),
//                              undefined: truncation (bias 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gauss_pkg;

  localparam int KERNEL_FRAC_BITS = 8;

`ifdef GAUSS_ROUND_EN
  localparam int ROUND_BIAS = 128;
`else
  localparam int ROUND_BIAS = 0;
`endif

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    ACCUM   = 2'd1,
    ROUND   = 2'd2,
    OUT     = 2'd3
  } conv_state_t;

  // Wide enough for MAX_KERNEL^2 products of a full-scale pixel and weight.
  function automatic int acc_width(input int max_kernel, input int pix_w);
    return pix_w + KERNEL_FRAC_BITS + $clog2(max_kernel * max_kernel);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gauss_conv_window_mac.sv
// ============================================================================
// Module   : gauss_conv_window_mac (gauss_mac)
// Purpose  : Registered multiply-accumulate: acc += pix * weight when en,
//            synchronous clear when clr, asynchronous clear on rst.
// Ports    : clk, rst        clock / async active-high reset
//            clr, en         clear accumulator / accumulate this cycle
//            pix, weight     pixel (PIX_W) and Q0.8 weight (8 bits)
//            acc             accumulated sum (ACC_W)
// Config   : none (GAUSS_ROUND_EN does not affect this block)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gauss_mac #(
  parameter int PIX_W = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] pix,
  input  logic [7:0]       weight,
  output logic [ACC_W-1:0] acc
);

  logic [PIX_W+7:0] w_prod;

  assign w_prod = {8'b0, pix} * {{PIX_W{1'b0}}, weight};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(w_prod);
    end
  end

endmodule

`default_nettype wire

// File: rtl/gauss_conv_window.sv
// ============================================================================
// Module   : gauss_conv_window
// Purpose  : Convolves a latched Q0.8 kernel with one size x size pixel
//            window (raster order), producing one rounded/saturated pixel
//            per window.
// Ports    : clk, rst                      clock / async active-high reset
//            kernel_in, kernel_size,       kernel weights [y][x], active edge
//            kernel_load                   length, one-cycle latch pulse
//            pix_in, pix_valid, pix_ready  window pixel stream
//            out_pix, out_valid, out_ready filtered pixel stream
//            busy                          window partially/fully accumulated
//            err                           sticky illegal kernel_size on load
// Config   : GAUSS_ROUND_EN selects round-half-up instead of truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gauss_conv_window
  import gauss_pkg::*;
#(
  parameter int MAX_KERNEL = 3,
  parameter int PIX_W      = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]  kernel_in,
  input  logic [$clog2(MAX_KERNEL+1)-1:0]             kernel_size,
  input  logic                                        kernel_load,
  input  logic [PIX_W-1:0]                            pix_in,
  input  logic                                        pix_valid,
  output logic                                        pix_ready,
  output logic [PIX_W-1:0]                            out_pix,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        busy,
  output logic                                        err
);

  localparam int              SZ_W    = $clog2(MAX_KERNEL + 1);
  localparam int              ACC_W   = acc_width(MAX_KERNEL, PIX_W);
  localparam logic [SZ_W-1:0] MAX_SZ  = SZ_W'(MAX_KERNEL);
  localparam logic [ACC_W:0]  BIAS    = (ACC_W+1)'(ROUND_BIAS);
  localparam logic [ACC_W:0]  PIX_MAX = (ACC_W+1)'((1 << PIX_W) - 1);

  conv_state_t r_state, w_state_nxt;

  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] r_kernel;
  logic [SZ_W-1:0]  r_size;
  logic [SZ_W-1:0]  r_cx, r_cy;
  logic             r_busy, r_err;
  logic [PIX_W-1:0] r_out_pix;
  logic [ACC_W-1:0] w_acc;

  logic             w_load_ok, w_size_ok, w_hs;
  logic             w_cx_last, w_cy_last, w_last, w_mac_clr;
  logic [7:0]       w_weight;
  logic [ACC_W:0]   w_sum, w_res;

  // A load is only honoured before the first pixel of a window; r_busy
  // doubles as the "pixels consumed" flag.
  assign w_load_ok = kernel_load &&
                     ((r_state == UNARMED) || ((r_state == ACCUM) && !r_busy));
  assign w_size_ok = (kernel_size != '0) && (kernel_size <= MAX_SZ);
  assign w_hs      = pix_valid && pix_ready;
  assign w_cx_last = (r_cx == r_size - SZ_W'(1));
  assign w_cy_last = (r_cy == r_size - SZ_W'(1));
  assign w_last    = w_hs && w_cx_last && w_cy_last;
  assign w_weight  = r_kernel[r_cy][r_cx];
  assign w_mac_clr = (r_state == OUT) && out_ready;

  assign w_sum = {1'b0, w_acc} + BIAS;
  assign w_res = w_sum >> KERNEL_FRAC_BITS;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= UNARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      UNARMED: if (w_load_ok) w_state_nxt = w_size_ok ? ACCUM : UNARMED;
      ACCUM: begin
        if (w_load_ok)   w_state_nxt = w_size_ok ? ACCUM : UNARMED;
        else if (w_last) w_state_nxt = ROUND;
      end
      ROUND:   w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = UNARMED;
    endcase
  end

  // Output logic; a same-cycle accepted load steals the pixel slot.
  always_comb begin
    pix_ready = (r_state == ACCUM) && !w_load_ok;
    out_valid = (r_state == OUT);
  end

  // Kernel, counters and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kernel  <= '0;
      r_size    <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_out_pix <= '0;
    end else begin
      if (w_load_ok) begin
        r_err <= !w_size_ok;
        if (w_size_ok) begin
          r_kernel <= kernel_in;
          r_size   <= kernel_size;
        end
      end

      if (w_hs) begin
        r_busy <= 1'b1;
        if (w_cx_last) begin
          r_cx <= '0;
          r_cy <= w_cy_last ? '0 : r_cy + SZ_W'(1);
        end else begin
          r_cx <= r_cx + SZ_W'(1);
        end
      end

      if (r_state == ROUND) begin
        r_out_pix <= (w_res > PIX_MAX) ? {PIX_W{1'b1}} : w_res[PIX_W-1:0];
      end

      if (w_mac_clr) begin
        r_busy <= 1'b0;
      end
    end
  end

  gauss_mac #(
    .PIX_W (PIX_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_mac_clr),
    .en     (w_hs),
    .pix    (pix_in),
    .weight (w_weight),
    .acc    (w_acc)
  );

  assign out_pix = r_out_pix;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gauss_conv_window.sv
// ============================================================================
// Module   : tb_gauss_conv_window
// Purpose  : Self-checking bench for gauss_conv_window: table of directed
//            windows, hand-written corner sequences and randomized windows
//            checked against an arithmetic reference model.
// Config   : honours GAUSS_ROUND_EN for the expected rounding bias.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gauss_conv_window;

  localparam int MK = 3;
  localparam int PW = 8;
`ifdef GAUSS_ROUND_EN
  localparam int BIAS = 128;
`else
  localparam int BIAS = 0;
`endif

  typedef logic [MK-1:0][MK-1:0][7:0] kern_t;
  typedef logic [7:0] pix_arr_t [9];
  typedef struct {
    kern_t    k;
    int       size;
    pix_arr_t px;
    int       exp;
    bit       bad_first;
    int       hold;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  kern_t         kernel_in;
  logic [1:0]    kernel_size;
  logic          kernel_load;
  logic [PW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [PW-1:0] out_pix;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gauss_conv_window #(.MAX_KERNEL(MK), .PIX_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .kernel_in   (kernel_in),
    .kernel_size (kernel_size),
    .kernel_load (kernel_load),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .out_pix     (out_pix),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: weighted sum in raster order, bias, shift, clamp.
  function automatic int model(input kern_t k, input int size, input pix_arr_t px);
    int sum = 0;
    int r;
    for (int i = 0; i < size * size; i++) begin
      sum += int'(px[i]) * int'(k[i / size][i % size]);
    end
    r = (sum + BIAS) / 256;
    return (r > 255) ? 255 : r;
  endfunction

  // All tasks enter and leave just after a rising edge.
  task automatic load_kernel(input kern_t k, input int size);
    kernel_in   = k;
    kernel_size = 2'(size);
    kernel_load = 1'b1;
    @(posedge clk); #1;
    kernel_load = 1'b0;
  endtask

  task automatic feed(input pix_arr_t px, input int first, input int count, input bit gaps);
    bit done;
    for (int i = first; i < first + count; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      pix_valid = 1'b1;
      pix_in    = px[i];
      done      = 1'b0;
      for (int w = 0; w < 16 && !done; w++) begin
        @(negedge clk);
        if (pix_ready) done = 1'b1;
        @(posedge clk); #1;
      end
      if (!done) chk("pix_accept_timeout", 0, 1);
    end
    pix_valid = 1'b0;
  endtask

  // Called right after the last pixel's accepting edge (cycle N ends).
  task automatic finish_window(input int exp, input int hold, input string name);
    @(negedge clk);
    chk({name, "_valid_at_n1"}, int'(out_valid), 0);
    @(posedge clk); #1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, int'(out_valid), 1);
      chk({name, "_hold_pix"}, int'(out_pix), exp);
      chk({name, "_hold_pix_ready"}, int'(pix_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_valid_at_n2"}, int'(out_valid), 1);
    chk({name, "_out_pix"}, int'(out_pix), exp);
    chk({name, "_busy_full"}, int'(busy), 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_valid_cleared"}, int'(out_valid), 0);
    chk({name, "_busy_cleared"}, int'(busy), 0);
    chk({name, "_rearmed_ready"}, int'(pix_ready), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t     vecs[4];
    kern_t    ka, kb;
    pix_arr_t pa;
    int       sz, e;

    rst = 1'b1; kernel_in = '0; kernel_size = '0; kernel_load = 1'b0;
    pix_in = '0; pix_valid = 1'b0; out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_pix_ready", int'(pix_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pix", int'(out_pix), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    vecs[0].k = '0; vecs[0].k[1][1] = 8'd255; vecs[0].size = 3;
    vecs[0].px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd200, 8'd60, 8'd70, 8'd80, 8'd90};
    vecs[0].exp = 199; vecs[0].bad_first = 1'b0; vecs[0].hold = 0;

    vecs[1].k = {9{8'd28}}; vecs[1].size = 3;
    vecs[1].px = '{default: 8'd255};
    vecs[1].exp = 251; vecs[1].bad_first = 1'b0; vecs[1].hold = 0;

    vecs[2].k = {9{8'd255}}; vecs[2].size = 3;
    vecs[2].px = '{default: 8'd255};
    vecs[2].exp = 255; vecs[2].bad_first = 1'b0; vecs[2].hold = 5;

    vecs[3].k = '0; vecs[3].size = 2;
    vecs[3].k[0][0] = 8'd64; vecs[3].k[0][1] = 8'd64;
    vecs[3].k[1][0] = 8'd64; vecs[3].k[1][1] = 8'd64;
    vecs[3].px = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[3].exp = 100; vecs[3].bad_first = 1'b1; vecs[3].hold = 0;

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].bad_first) begin
        load_kernel(vecs[v].k, 0);
        @(negedge clk);
        chk($sformatf("vec%0d_bad_err", v), int'(err), 1);
        chk($sformatf("vec%0d_bad_pix_ready", v), int'(pix_ready), 0);
        @(posedge clk); #1;
      end
      load_kernel(vecs[v].k, vecs[v].size);
      @(negedge clk);
      chk($sformatf("vec%0d_load_err", v), int'(err), 0);
      chk($sformatf("vec%0d_load_ready", v), int'(pix_ready), 1);
      @(posedge clk); #1;
      feed(vecs[v].px, 0, 1, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_first", v), int'(busy), 1);
      @(posedge clk); #1;
      feed(vecs[v].px, 1, vecs[v].size * vecs[v].size - 1, 1'b0);
      finish_window(vecs[v].exp, vecs[v].hold, $sformatf("vec%0d", v));
    end

    // Load mid-window (illegal size) must be ignored entirely.
    ka = {9{8'd20}}; ka[1][1] = 8'd100;
    pa = '{8'd1, 8'd50, 8'd99, 8'd150, 8'd200, 8'd250, 8'd7, 8'd128, 8'd64};
    load_kernel(ka, 3);
    feed(pa, 0, 2, 1'b0);
    load_kernel({9{8'd1}}, 0);
    @(negedge clk);
    chk("ignored_load_err", int'(err), 0);
    chk("ignored_load_busy", int'(busy), 1);
    @(posedge clk); #1;
    feed(pa, 2, 7, 1'b0);
    finish_window(model(ka, 3, pa), 0, "ignored_load");

    // Load and pixel collide in an empty window: load wins, pixel is refused.
    kb = '0; kb[0][0] = 8'd10; kb[0][1] = 8'd90; kb[1][0] = 8'd30; kb[1][1] = 8'd126;
    kernel_in = kb; kernel_size = 2'd2; kernel_load = 1'b1;
    pix_valid = 1'b1; pix_in = 8'd7;
    @(negedge clk);
    chk("collide_pix_ready", int'(pix_ready), 0);
    @(posedge clk); #1;
    kernel_load = 1'b0; pix_valid = 1'b0;
    pa = '{8'd200, 8'd10, 8'd255, 8'd33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    feed(pa, 0, 4, 1'b0);
    finish_window(model(kb, 2, pa), 0, "collide");

    // Randomized windows against the reference model
    for (int n = 0; n < 25; n++) begin
      sz = $urandom_range(1, 3);
      ka = '0;
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          ka[y][x] = 8'($urandom_range(0, 512 / (sz * sz)));
      for (int i = 0; i < 9; i++) pa[i] = 8'($urandom_range(0, 255));
      load_kernel(ka, sz);
      feed(pa, 0, sz * sz, 1'b1);
      finish_window(model(ka, sz, pa), $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    // Reset after 4 of 9 pixels
    ka = {9{8'd28}};
    for (int i = 0; i < 9; i++) pa[i] = 8'(17 * i + 5);
    load_kernel(ka, 3);
    feed(pa, 0, 4, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pix_ready", int'(pix_ready), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_pix", int'(out_pix), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    pix_valid = 1'b1; pix_in = 8'd255;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_unarmed_ready", int'(pix_ready), 0);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    load_kernel(ka, 3);
    feed(pa, 0, 9, 1'b0);
    e = model(ka, 3, pa);
    finish_window(e, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
